// File: rtl/player_controller.sv
`default_nettype none
// =====================================================================
// Module      : player_controller
// Description : Button sync/debounce, player FSM and two-phase game-tick
//               sequencer feeding player_physics; drives sprite selects.
// Revision    : 1.0 - initial release
// =====================================================================
module player_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned ANIM_DIV        = 6,
    parameter int unsigned RESTART_FRAMES  = 30
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick_i,
    input  logic       btn_jump_i,
    input  logic       btn_down_i,
    input  logic       jump_done_i,
    input  logic       collision_i,
    output logic [1:0] game_tick_o,
    output logic       jump_pulse_o,
    output logic       button_down_o,
    output logic       phys_rst_n_o,
    output logic [1:0] player_state_o,
    output logic       ducking_o,
    output logic [1:0] anim_frame_o
);

    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned ANIM_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int unsigned DEAD_W = $clog2(RESTART_FRAMES + 1);

    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ANIM_W-1:0] ANIM_MAX = ANIM_W'(ANIM_DIV - 1);
    localparam logic [DEAD_W-1:0] DEAD_MAX = DEAD_W'(RESTART_FRAMES);

    localparam logic [1:0] GT_IDLE = 2'b00;
    localparam logic [1:0] GT_VEL  = 2'b01;
    localparam logic [1:0] GT_POS  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_JUMP = 2'b10,
        S_DEAD = 2'b11
    } state_t;

    // Bit 0 = jump button, bit 1 = down button
    logic [1:0]      btn_raw;
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      deb_q;
    logic [1:0]      deb_prev_q;
    logic [DB_W-1:0] db_cnt_q [2];

    state_t            state_q;
    logic [1:0]        game_tick_q;
    logic              jump_pulse_q;
    logic              phys_rst_n_q;
    logic              jump_req_q;
    logic [DEAD_W-1:0] dead_cnt_q;
    logic [ANIM_W-1:0] anim_div_q;
    logic [1:0]        anim_q;

    logic w_jump_edge;
    logic w_active;
    logic w_hit;
    logic w_start;
    logic w_launch;
    logic w_down;

    assign btn_raw = {btn_down_i, btn_jump_i};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            deb_prev_q  <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            for (int b = 0; b < 2; b++) begin
                if (sync2_q[b] == deb_q[b]) begin
                    db_cnt_q[b] <= '0;
                end else if (db_cnt_q[b] == DB_MAX) begin
                    deb_q[b]    <= sync2_q[b];
                    db_cnt_q[b] <= '0;
                end else begin
                    db_cnt_q[b] <= db_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    assign w_jump_edge = deb_q[0] & ~deb_prev_q[0];
    assign w_active    = (state_q == S_RUN) || (state_q == S_JUMP);
    assign w_down      = deb_q[1] & w_active;
    assign w_hit       = collision_i & (state_q != S_IDLE);
    assign w_start     = frame_tick_i & w_active & (game_tick_q == GT_IDLE) & ~w_hit;
    // Down has priority over a pending jump: the request is consumed without launching
    assign w_launch    = w_start & (state_q == S_RUN) & jump_req_q & ~w_down;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            game_tick_q  <= GT_IDLE;
            jump_pulse_q <= 1'b0;
            phys_rst_n_q <= 1'b1;
            jump_req_q   <= 1'b0;
            dead_cnt_q   <= '0;
            anim_div_q   <= '0;
            anim_q       <= 2'b00;
        end else begin
            jump_pulse_q <= w_launch;
            phys_rst_n_q <= 1'b1;

            if (w_hit || !w_active) begin
                game_tick_q <= GT_IDLE;
            end else if (w_start) begin
                game_tick_q <= GT_VEL;
            end else if (game_tick_q == GT_VEL) begin
                game_tick_q <= GT_POS;
            end else begin
                game_tick_q <= GT_IDLE;
            end

            if (w_hit || !w_active) begin
                anim_div_q <= '0;
                anim_q     <= 2'b00;
            end else if ((state_q == S_RUN) && frame_tick_i) begin
                if (anim_div_q == ANIM_MAX) begin
                    anim_div_q <= '0;
                    anim_q     <= anim_q + 2'd1;
                end else begin
                    anim_div_q <= anim_div_q + 1'b1;
                end
            end

            if (w_hit) begin
                state_q    <= S_DEAD;
                jump_req_q <= 1'b0;
                if (state_q != S_DEAD) begin
                    dead_cnt_q <= '0;
                end else if (frame_tick_i && (dead_cnt_q != DEAD_MAX)) begin
                    dead_cnt_q <= dead_cnt_q + 1'b1;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (w_jump_edge) state_q <= S_RUN;
                    end
                    S_RUN: begin
                        if (w_start && jump_req_q) begin
                            jump_req_q <= 1'b0;
                            if (!w_down) state_q <= S_JUMP;
                        end else if (w_jump_edge) begin
                            jump_req_q <= 1'b1;
                        end
                    end
                    S_JUMP: begin
                        if ((game_tick_q == GT_POS) && jump_done_i) state_q <= S_RUN;
                    end
                    default: begin
                        // The cycle after the physics-reset pulse leaves DEAD
                        if (!phys_rst_n_q) begin
                            state_q    <= S_RUN;
                            dead_cnt_q <= '0;
                        end else begin
                            if (frame_tick_i && (dead_cnt_q != DEAD_MAX)) begin
                                dead_cnt_q <= dead_cnt_q + 1'b1;
                            end
                            if (w_jump_edge && (dead_cnt_q == DEAD_MAX)) begin
                                phys_rst_n_q <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign game_tick_o    = game_tick_q;
    assign jump_pulse_o   = jump_pulse_q;
    assign phys_rst_n_o   = phys_rst_n_q;
    assign player_state_o = state_q;
    assign anim_frame_o   = anim_q;
    assign button_down_o  = w_down;
    assign ducking_o      = deb_q[1] & (state_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_player_controller.sv
`default_nettype none
// =====================================================================
// Module      : tb_player_controller
// Description : Directed self-checking bench for player_controller.
// Revision    : 1.0 - initial release
// =====================================================================
module tb_player_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_tick;
    logic       btn_jump;
    logic       btn_down;
    logic       jump_done;
    logic       collision;
    logic [1:0] game_tick;
    logic       jump_pulse;
    logic       button_down;
    logic       phys_rst_n;
    logic [1:0] player_state;
    logic       ducking;
    logic [1:0] anim_frame;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] gt;
        logic       jp;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    player_controller dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .frame_tick_i   (frame_tick),
        .btn_jump_i     (btn_jump),
        .btn_down_i     (btn_down),
        .jump_done_i    (jump_done),
        .collision_i    (collision),
        .game_tick_o    (game_tick),
        .jump_pulse_o   (jump_pulse),
        .button_down_o  (button_down),
        .phys_rst_n_o   (phys_rst_n),
        .player_state_o (player_state),
        .ducking_o      (ducking),
        .anim_frame_o   (anim_frame)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame: expected phases are queued when the tick is driven and
    // popped as the DUT steps through them. jd/coll are driven in the
    // position-phase cycle; hold2 repeats the tick while the sequencer is busy.
    task automatic frame(input bit active, input bit jp, input bit jd, input bit coll, input bit hold2);
        exp_t e;
        frame_tick = 1'b1;
        if (active) begin
            exp_q.push_back(exp_t'{gt: 2'b01, jp: jp});
            exp_q.push_back(exp_t'{gt: 2'b10, jp: 1'b0});
        end else begin
            exp_q.push_back(exp_t'{gt: 2'b00, jp: 1'b0});
            exp_q.push_back(exp_t'{gt: 2'b00, jp: 1'b0});
        end
        exp_q.push_back(exp_t'{gt: 2'b00, jp: 1'b0});
        for (int i = 0; i < 3; i++) begin
            step();
            frame_tick = (i == 0) ? hold2 : 1'b0;
            if (i == 1) begin
                jump_done = jd;
                collision = coll;
            end else begin
                jump_done = 1'b0;
                collision = 1'b0;
            end
            e = exp_q.pop_front();
            chk("game_tick", 8'(game_tick), 8'(e.gt));
            chk("jump_pulse", 8'(jump_pulse), 8'(e.jp));
        end
    endtask

    task automatic press_jump();
        btn_jump = 1'b1;
        repeat (8) step();
        btn_jump = 1'b0;
        repeat (10) step();
    endtask

    initial begin
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        btn_jump   = 1'b1;
        btn_down   = 1'b1;
        jump_done  = 1'b0;
        collision  = 1'b0;

        // Reset with buttons held high
        repeat (3) step();
        chk("rst_game_tick", 8'(game_tick), 8'h0);
        chk("rst_jump_pulse", 8'(jump_pulse), 8'h0);
        chk("rst_button_down", 8'(button_down), 8'h0);
        chk("rst_phys_rst_n", 8'(phys_rst_n), 8'h1);
        chk("rst_state", 8'(player_state), 8'h0);
        chk("rst_ducking", 8'(ducking), 8'h0);
        chk("rst_anim", 8'(anim_frame), 8'h0);
        btn_jump = 1'b0;
        btn_down = 1'b0;
        reset_n  = 1'b1;
        repeat (10) step();
        chk("idle_state", 8'(player_state), 8'h0);

        // IDLE -> RUN exactly 7 cycles after the raw press, no pulse
        for (int i = 1; i <= 8; i++) begin
            btn_jump = 1'b1;
            step();
            chk("start_state", 8'(player_state), (i >= 7) ? 8'h1 : 8'h0);
            chk("start_no_pulse", 8'(jump_pulse), 8'h0);
        end
        btn_jump = 1'b0;
        repeat (10) step();
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("run_state", 8'(player_state), 8'h1);

        // Jump from RUN, landing on jump_done in the position phase
        press_jump();
        frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("jump_state", 8'(player_state), 8'h2);
        frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("land_state", 8'(player_state), 8'h1);

        // Three-cycle glitch produces no debounced edge
        btn_jump = 1'b1;
        repeat (3) step();
        btn_jump = 1'b0;
        repeat (5) step();
        for (int k = 0; k < 5; k++) frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("glitch_state", 8'(player_state), 8'h1);

        // Collision beats jump_done in the same position-phase cycle
        press_jump();
        frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("jump2_state", 8'(player_state), 8'h2);
        frame(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("dead_state", 8'(player_state), 8'h3);
        chk("dead_anim", 8'(anim_frame), 8'h0);
        for (int k = 0; k < 10; k++) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 18; i++) begin
            btn_jump = (i <= 8);
            step();
            chk("early_phys_rst_n", 8'(phys_rst_n), 8'h1);
            chk("early_state", 8'(player_state), 8'h3);
        end
        for (int k = 0; k < 20; k++) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 18; i++) begin
            btn_jump = (i <= 8);
            step();
            chk("restart_phys_rst_n", 8'(phys_rst_n), (i == 7) ? 8'h0 : 8'h1);
            chk("restart_state", 8'(player_state), (i >= 8) ? 8'h1 : 8'h3);
        end
        chk("restart_anim", 8'(anim_frame), 8'h0);

        // Ducking and run animation
        btn_down = 1'b1;
        repeat (8) step();
        chk("duck_button_down", 8'(button_down), 8'h1);
        chk("duck_ducking", 8'(ducking), 8'h1);
        for (int k = 1; k <= 12; k++) begin
            frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("anim_frame", 8'(anim_frame), 8'((k / 6) % 4));
        end
        press_jump();
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("down_blocks_jump", 8'(player_state), 8'h1);
        btn_down = 1'b0;
        repeat (10) step();
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("req_cleared_state", 8'(player_state), 8'h1);
        chk("up_button_down", 8'(button_down), 8'h0);
        press_jump();
        frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("jump3_state", 8'(player_state), 8'h2);
        btn_down = 1'b1;
        repeat (8) step();
        chk("jump_button_down", 8'(button_down), 8'h1);
        chk("jump_ducking", 8'(ducking), 8'h0);
        chk("jump_hold_state", 8'(player_state), 8'h2);

        chk("scoreboard_empty", 8'(exp_q.size()), 8'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
